// File: rtl/pc_trace_uart.sv
// PC trace capture: records {pc, inst} whenever the PC changes, buffers them in a FIFO,
// and streams each record out as eight 8N1 UART frames, MSB byte first.
module pc_trace_uart #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    input  logic [31:0]              pc,
    input  logic [31:0]              inst,
    input  logic                     enable,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_next;

    logic [31:0]   prev_pc;
    logic          first;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;
    logic [63:0]   shreg;
    logic [2:0]    byte_idx;
    logic [2:0]    bit_idx;
    logic [CW-1:0] clk_cnt;
    logic          bit_done;
    logic [7:0]    cur_byte;

    assign push   = enable && (first || (pc != prev_pc));
    assign pop    = (state == IDLE) && (fifo_level != '0);
    assign full   = (fifo_level == LEVEL_FULL);
    // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
    assign accept = push && (!full || pop);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            prev_pc <= '0;
            first   <= 1'b1;
        end else begin
            prev_pc <= pc;
            if (enable) begin
                first <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            mem[wr_ptr] <= {pc, inst};
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                fifo_level <= fifo_level + (AW + 1)'(1);
            end else if (pop && !accept) begin
                fifo_level <= fifo_level - (AW + 1)'(1);
            end
            if (push && !accept && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bit_done   = (clk_cnt == CNT_LAST);
        case (state)
            IDLE:    if (pop) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
            STOP:    if (bit_done) state_next = (byte_idx == 3'd7) ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            shreg    <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            clk_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        byte_idx <= '0;
                    end
                end
                START: begin
                    clk_cnt <= bit_done ? '0 : clk_cnt + CW'(1);
                end
                DATA: begin
                    clk_cnt <= bit_done ? '0 : clk_cnt + CW'(1);
                    if (bit_done) begin
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    clk_cnt <= bit_done ? '0 : clk_cnt + CW'(1);
                    if (bit_done && (byte_idx != 3'd7)) begin
                        byte_idx <= byte_idx + 3'd1;
                    end
                end
                default: begin
                    clk_cnt <= '0;
                end
            endcase
        end
    end

    // Byte k of the record sits at bits [63-8k -: 8]; {~k, 3'b000} is that base offset.
    always_comb begin
        cur_byte = shreg[{~byte_idx, 3'b000} +: 8];
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = cur_byte[bit_idx];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_pc_trace_uart.sv
// Randomised and directed bench for pc_trace_uart: queue-based reference model plus a
// UART frame monitor that checks every serial cycle against the expected byte stream.
module tb_pc_trace_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_in  = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable  = 1'b0;
    logic [31:0]   pc      = '0;
    logic [31:0]   inst    = '0;
    logic          tx;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic [15:0]   drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    pc_trace_uart #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(DEPTH)
    ) dut (
        .clk_in(clk_in),
        .reset_n(reset_n),
        .pc(pc),
        .inst(inst),
        .enable(enable),
        .tx(tx),
        .busy(busy),
        .fifo_level(fifo_level),
        .drop_cnt(drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a bounded queue of records and a countdown for the serializer.
    logic [63:0] m_q[$];
    logic [7:0]  exp_bytes[$];
    bit          m_first = 1'b1;
    logic [31:0] m_prev  = '0;
    int          m_drop  = 0;
    int          m_left  = 0;
    bit          do_pop;
    bit          do_push;
    logic [63:0] r;

    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            exp_bytes.delete();
            m_first = 1'b1;
            m_prev  = '0;
            m_drop  = 0;
            m_left  = 0;
        end else begin
            do_pop  = (m_left == 0) && (m_q.size() > 0);
            do_push = enable && (m_first || (pc != m_prev));
            if (do_pop) begin
                r = m_q.pop_front();
                for (int b = 7; b >= 0; b--) exp_bytes.push_back(r[b*8 +: 8]);
                m_left = 80 * CPB;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (do_push) begin
                if (m_q.size() < DEPTH) m_q.push_back({pc, inst});
                else if (m_drop != 16'hFFFF) m_drop++;
            end
            m_prev = pc;
            if (enable) m_first = 1'b0;
        end
    end

    always @(negedge clk_in) begin
        check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
        check("busy", 64'(busy), 64'(m_left > 0));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end

    // UART monitor: every cycle of a frame is compared with the bit it should carry.
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    int         rx_bytes  = 0;
    int         pos;
    logic [7:0] rx_exp;
    logic       want;

    always @(negedge clk_in) begin
        if (!reset_n) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && (tx == 1'b0)) begin
                check("frame_expected", 64'(exp_bytes.size() > 0), 64'd1);
                if (exp_bytes.size() > 0) begin
                    rx_exp    = exp_bytes.pop_front();
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end
            if (rx_active) begin
                pos  = rx_cnt / CPB;
                want = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : rx_exp[pos-1];
                check("tx_bit", 64'(tx), 64'(want));
                rx_cnt++;
                if (rx_cnt == 10 * CPB) begin
                    rx_active = 1'b0;
                    rx_bytes++;
                end
            end
        end
    end

    task automatic wait_drain(input int limit);
        int n = 0;
        while (!((busy == 1'b0) && (fifo_level == '0)) && (n < limit)) begin
            @(negedge clk_in);
            n++;
        end
        check("drain_in_time", 64'(n < limit), 64'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy != 1'b0) && (n < limit)) begin
            @(negedge clk_in);
            n++;
        end
        check("idle_in_time", 64'(n < limit), 64'd1);
    endtask

    task automatic wait_tx_low(input int limit);
        int n = 0;
        while ((tx != 1'b0) && (n < limit)) begin
            @(negedge clk_in);
            n++;
        end
        check("tx_low_in_time", 64'(n < limit), 64'd1);
    endtask

    initial begin
        int start_bytes;

        repeat (3) @(negedge clk_in);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        reset_n = 1'b1;
        @(negedge clk_in);

        // First capture plus one PC change, then a long steady PC.
        start_bytes = rx_bytes;
        pc     = 32'h0040_0000;
        inst   = 32'h3C01_1001;
        enable = 1'b1;
        @(negedge clk_in);
        pc = 32'h0040_0004;
        repeat (100) @(negedge clk_in);
        wait_drain(2000);
        check("single_bytes", 64'(rx_bytes - start_bytes), 64'd16);
        check("single_flush", 64'(exp_bytes.size()), 64'd0);

        // Ten PC changes on consecutive cycles overflow a 4-entry FIFO.
        for (int i = 0; i < 10; i++) begin
            pc = 32'h0050_0000 + 32'(i * 4);
            @(negedge clk_in);
        end
        check("ovf_drop", 64'(drop_cnt), 64'd5);
        check("ovf_level", 64'(fifo_level), 64'd4);

        // Push on the very edge the serializer pops from a full FIFO.
        wait_idle(400);
        pc = 32'h0060_0000;
        @(negedge clk_in);
        check("full_pp_level", 64'(fifo_level), 64'd4);
        check("full_pp_drop", 64'(drop_cnt), 64'd5);
        check("full_pp_busy", 64'(busy), 64'd1);

        // Capture disabled: PC changes are ignored, buffered records still drain.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc = 32'h0070_0000 + 32'(i * 4);
            @(negedge clk_in);
        end
        check("gate_drop", 64'(drop_cnt), 64'd5);
        wait_drain(3000);
        check("gate_level", 64'(fifo_level), 64'd0);
        check("gate_flush", 64'(exp_bytes.size()), 64'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(9) != 0);
            if ($urandom_range(29) == 0) pc = $urandom;
            inst = $urandom;
            @(negedge clk_in);
        end
        wait_drain(3000);
        check("rand_flush", 64'(exp_bytes.size()), 64'd0);

        // Asynchronous reset in the middle of a frame with records buffered.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h0080_0000 + 32'(i * 4);
            @(negedge clk_in);
        end
        wait_tx_low(2000);
        repeat (6) @(negedge clk_in);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_tx", 64'(tx), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_level", 64'(fifo_level), 64'd0);
        enable = 1'b0;
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_in);
        check("post_rst_level", 64'(fifo_level), 64'd0);
        check("post_rst_drop", 64'(drop_cnt), 64'd0);
        check("post_rst_tx", 64'(tx), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_trace_uart.md
# pc_trace_uart

Downstream trace stage for the multicycle MIPS SoC. It watches the `pc` and `inst` outputs of the SoC top level and captures one 64-bit record {pc, inst} each time the PC changes. Records are buffered in a FIFO and streamed out as 8N1 UART frames, so execution can be logged on the board without a logic analyser. When the FIFO is full, records are dropped and counted.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit; must be ≥ 2.
- `DEPTH`, 16: FIFO entries; must be a power of two and ≥ 2.
- `clk_in`  in  1: single clock domain, shared with the SoC.
- `reset_n`  in  1: asynchronous, active-low reset. It is already decided that the block has one clock, and that reset is asynchronous and active-low.
- `pc`  in  32: SoC fake PC.
- `inst`  in  32: SoC instruction register.
- `enable`  in  1: capture enable; serializer keeps draining when 0.
- `tx`  out  1: UART serial output; idle high.
- `busy`  out  1: high while the serializer is not in IDLE.
- `fifo_level`  out  $clog2(DEPTH)+1: number of occupied FIFO entries.
- `drop_cnt`  out  16: records lost to overflow; saturates at 0xFFFF.

## Operation
- **Capture registers**
  - `prev_pc` loads `pc` on every clock edge, regardless of `enable`.
  - `first` is set by reset and cleared on the first edge where `enable`=1.
- **Push condition:** `enable` && (`first` || `pc` != `prev_pc`).
  - The pushed record is {`pc`, `inst`} as sampled at that edge.
  - Known limitation: a self-loop (`j .`) is logged only once.
- **FIFO**
  - Circular buffer with read/write pointers that wrap at DEPTH.
  - Pop occurs when the serializer is in IDLE and `fifo_level` > 0.
  - Push and pop in the same cycle: both take effect and `fifo_level` is unchanged. This holds even when the FIFO is full, so the push is accepted.
  - Push while full with no pop: the record is discarded and `drop_cnt` increments by 1, saturating at 0xFFFF.
- **Serializer FSM:** states IDLE, START, DATA, STOP.
  - IDLE → START on pop; the record is loaded into the shift register and the byte index is reset to 0.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then → DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, then → STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
    - If byte index < 7: increment it and → START.
    - Otherwise → IDLE.
  - Byte order: pc[31:24], pc[23:16], pc[15:8], pc[7:0], inst[31:24], inst[23:16], inst[15:8], inst[7:0].
- **`busy`** = (state != IDLE).

## Timing
- **Reset values:** `tx`=1, `busy`=0, `fifo_level`=0, `drop_cnt`=0, state=IDLE, `first`=1, `prev_pc`=0, pointers=0.
- **Reset mid-operation:** all of the above take effect immediately (asynchronous).
  - Any frame in progress is truncated and `tx` returns high immediately.
  - Buffered records are lost.
- **Push latency:** the push condition is true during cycle n; `fifo_level` reflects the new entry after edge n.
- **Pop latency:** the FIFO is non-empty after edge e. The pop and the IDLE → START transition occur at edge e+1, and `tx` falls after edge e+1.
- **Record duration:** 80·CLKS_PER_BIT cycles from the start bit of byte 0 to the end of the stop bit of byte 7. The FSM then spends exactly one cycle in IDLE before the next pop.
  - Back-to-back record period: 80·CLKS_PER_BIT + 1 cycles.
- **Bit counter:** counts 0 .. CLKS_PER_BIT−1. The state/bit advances on the edge where the counter equals CLKS_PER_BIT−1.
- **Combinational paths:** there are none from inputs to outputs; all outputs are registered or decoded from state.

## Test plan
- **Reset state:** assert `reset_n`=0 mid-frame. `tx`=1 and `busy`=0 within the same cycle; after release, `fifo_level`=0 and `drop_cnt`=0.
- **Single record** (CLKS_PER_BIT=4): `enable`=1, `pc` 0x00400000 → 0x00400004, `inst`=0x3C011001.
  - First capture: 0x00400000 is captured because `first` is set.
  - Second record: bytes 00 40 00 04 3C 01 10 01 appear on `tx`.
  - Each bit lasts 4 cycles and the whole record takes 320 cycles.
- **Steady PC:** hold `pc` constant for 100 cycles after the first capture → exactly 1 record.
- **Overflow** (DEPTH=4): 10 PC changes on consecutive cycles while the serializer is busy.
  - The first pops at once; 4 stay buffered and 5 are dropped.
  - Expect `drop_cnt`=5 and `fifo_level`=4.
- **Full FIFO, simultaneous push/pop:** push on the exact edge the serializer pops → accepted, `fifo_level` stays at DEPTH, `drop_cnt` unchanged.
- **Enable gating:** `enable`=0 while `pc` changes 5 times → no pushes; the serializer still drains previously buffered records to `fifo_level`=0.
